// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: MEM-stage store port, data-memory drain port,
// load hazard probe and occupancy. The master side drives stores, acks and
// load probes; the slave side is the buffer itself.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Store side.
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_funct3;
    logic          st_misalign;

    // Memory drain side.
    logic          mem_req;
    logic          mem_ack;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;

    // Load hazard probe.
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_hazard;

    // Occupancy.
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, st_funct3, mem_ack, ld_valid, ld_addr,
        input  st_ready, st_misalign, mem_req, mem_addr, mem_wdata, mem_be,
               ld_hazard, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, mem_ack, ld_valid, ld_addr,
        output st_ready, st_misalign, mem_req, mem_addr, mem_wdata, mem_be,
               ld_hazard, count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer. Formats stores into word-aligned writes with
// byte enables, queues them in a FIFO and drains them to data memory over a
// req/ack handshake. Loads hitting a queued word are flagged as hazards.
//
// Handshakes: a store transfers on a rising edge where st_valid && st_ready;
// a memory write transfers on a rising edge where mem_req && mem_ack. st_ready
// and mem_req depend only on registered state, and the head write fields stay
// stable while mem_req is high and mem_ack is low.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]    addr_q  [DEPTH];
    logic [31:0]    addr_d  [DEPTH];
    logic [31:0]    data_q  [DEPTH];
    logic [31:0]    data_d  [DEPTH];
    logic [3:0]     be_q    [DEPTH];
    logic [3:0]     be_d    [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           misalign_q, misalign_d;

    logic [1:0]     fmt_lo;
    logic [3:0]     fmt_be;
    logic [31:0]    fmt_wdata;
    logic           fmt_ok;
    logic           push_fire;
    logic           push;
    logic           pop;
    logic           ld_hit;

    assign bus.st_ready    = (count_q != CW'(DEPTH));
    assign bus.mem_req     = (count_q != '0);
    assign bus.mem_addr    = addr_q[head_q];
    assign bus.mem_wdata   = data_q[head_q];
    assign bus.mem_be      = be_q[head_q];
    assign bus.st_misalign = misalign_q;
    assign bus.count       = count_q;
    assign bus.ld_hazard   = bus.ld_valid && ld_hit;

    assign push_fire = bus.st_valid && bus.st_ready;
    assign push      = push_fire && fmt_ok;
    assign pop       = bus.mem_req && bus.mem_ack;

    // Lane formatting: turn a low-aligned store into byte enables and replicated data.
    always_comb begin
        fmt_lo    = bus.st_addr[1:0];
        fmt_be    = 4'b0000;
        fmt_wdata = bus.st_data;
        fmt_ok    = 1'b0;
        case (bus.st_funct3)
            3'b000: begin
                fmt_be    = 4'b0001 << fmt_lo;
                fmt_wdata = {4{bus.st_data[7:0]}};
                fmt_ok    = 1'b1;
            end
            3'b001: begin
                fmt_be    = fmt_lo[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = {2{bus.st_data[15:0]}};
                fmt_ok    = !fmt_lo[0];
            end
            3'b010: begin
                fmt_be    = 4'b1111;
                fmt_wdata = bus.st_data;
                fmt_ok    = (fmt_lo == 2'b00);
            end
            default: begin
                fmt_ok    = 1'b0;
            end
        endcase
    end

    // FIFO next state: write at tail on push, retire head on pop.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        misalign_d = push_fire && !fmt_ok;
        if (push) begin
            addr_d[tail_q]  = {bus.st_addr[31:2], 2'b00};
            data_d[tail_q]  = fmt_wdata;
            be_d[tail_q]    = fmt_be;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Hazard search over currently valid entries; a same-cycle push is not yet visible.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][31:2] == bus.ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    // State registers; reset clears pointers, valids and entry contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: lane formatting, drain handshake, hazard
// detection, full/wrap behaviour, misaligned drops and asynchronous reset.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    store_buffer_if #(.DEPTH(DEPTH)) bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: present one store for one clock edge.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        bus.st_valid  = 1'b1;
        bus.st_addr   = addr;
        bus.st_data   = data;
        bus.st_funct3 = f3;
        tick();
        bus.st_valid  = 1'b0;
    endtask

    // Driver: ack the head for one clock edge.
    task automatic do_ack();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.st_funct3 = '0;
        bus.mem_ack   = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset / idle.
        bus.ld_valid = 1'b1;
        #1;
        check("rst_count",    32'(bus.count), 32'd0);
        check("rst_mem_req",  32'(bus.mem_req), 32'd0);
        check("rst_st_ready", 32'(bus.st_ready), 32'd1);
        check("rst_hazard",   32'(bus.ld_hazard), 32'd0);
        check("rst_misalign", 32'(bus.st_misalign), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_be",   32'(bus.mem_be), 32'h0);
        bus.ld_valid = 1'b0;

        // SB at byte 3, held without ack.
        do_store(32'h0000_1003, 32'h0000_00AB, 3'b000);
        check("sb_req",   32'(bus.mem_req), 32'd1);
        check("sb_addr",  bus.mem_addr, 32'h0000_1000);
        check("sb_be",    32'(bus.mem_be), 32'b1000);
        check("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_1001;
        #1;
        check("sb_hazard", 32'(bus.ld_hazard), 32'd1);
        bus.ld_valid = 1'b0;
        #1;
        check("sb_hazard_noload", 32'(bus.ld_hazard), 32'd0);
        tick();
        tick();
        check("sb_hold_req",   32'(bus.mem_req), 32'd1);
        check("sb_hold_addr",  bus.mem_addr, 32'h0000_1000);
        check("sb_hold_be",    32'(bus.mem_be), 32'b1000);
        check("sb_hold_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        do_ack();
        check("sb_drained_req",   32'(bus.mem_req), 32'd0);
        check("sb_drained_count", 32'(bus.count), 32'd0);

        // SH upper half then SW, no ack.
        do_store(32'h0000_2002, 32'h0000_1234, 3'b001);
        do_store(32'h0000_2004, 32'hDEAD_BEEF, 3'b010);
        check("shsw_count", 32'(bus.count), 32'd2);
        check("sh_addr",    bus.mem_addr, 32'h0000_2000);
        check("sh_be",      32'(bus.mem_be), 32'b1100);
        check("sh_wdata",   bus.mem_wdata, 32'h1234_1234);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_2006;
        #1;
        check("hz_2006", 32'(bus.ld_hazard), 32'd1);
        bus.ld_addr  = 32'h0000_2008;
        #1;
        check("hz_2008", 32'(bus.ld_hazard), 32'd0);
        bus.ld_valid = 1'b0;
        do_ack();
        check("sw_addr",  bus.mem_addr, 32'h0000_2004);
        check("sw_be",    32'(bus.mem_be), 32'b1111);
        check("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_2000;
        #1;
        check("hz_popped", 32'(bus.ld_hazard), 32'd0);
        bus.ld_valid = 1'b0;
        do_ack();
        check("shsw_empty", 32'(bus.count), 32'd0);

        // Fill to DEPTH (pointers already at 3, so the tail wraps).
        for (int i = 0; i < DEPTH; i++) begin
            do_store(32'h0000_4000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 3'b010);
        end
        check("full_count", 32'(bus.count), 32'd4);
        check("full_ready", 32'(bus.st_ready), 32'd0);
        // Fifth store while full and acking: must not pass through.
        bus.st_valid  = 1'b1;
        bus.st_addr   = 32'h0000_4100;
        bus.st_data   = 32'h9999_9999;
        bus.st_funct3 = 3'b010;
        bus.mem_ack   = 1'b1;
        tick();
        bus.st_valid  = 1'b0;
        bus.mem_ack   = 1'b0;
        check("full_nopass_count", 32'(bus.count), 32'd3);
        check("full_nopass_head",  bus.mem_addr, 32'h0000_4004);
        // Push and pop together while not full.
        bus.mem_ack = 1'b1;
        do_store(32'h0000_4010, 32'h2222_0000, 3'b010);
        bus.mem_ack = 1'b0;
        check("pp_count", 32'(bus.count), 32'd3);
        check("pp_head",  bus.mem_addr, 32'h0000_4008);
        check("pp_data",  bus.mem_wdata, 32'h1111_0002);
        do_ack();
        check("wrap_head1", bus.mem_addr, 32'h0000_400C);
        check("wrap_data1", bus.mem_wdata, 32'h1111_0003);
        do_ack();
        check("wrap_head2", bus.mem_addr, 32'h0000_4010);
        check("wrap_data2", bus.mem_wdata, 32'h2222_0000);
        do_ack();
        check("wrap_empty", 32'(bus.count), 32'd0);
        check("wrap_ready", 32'(bus.st_ready), 32'd1);

        // Misaligned and illegal stores are dropped with a one-cycle pulse.
        do_store(32'h0000_3001, 32'h5555_5555, 3'b010);
        check("mis_sw_pulse", 32'(bus.st_misalign), 32'd1);
        check("mis_sw_count", 32'(bus.count), 32'd0);
        check("mis_sw_req",   32'(bus.mem_req), 32'd0);
        tick();
        check("mis_sw_clear", 32'(bus.st_misalign), 32'd0);
        do_store(32'h0000_3003, 32'h0000_6666, 3'b001);
        check("mis_sh_pulse", 32'(bus.st_misalign), 32'd1);
        check("mis_sh_count", 32'(bus.count), 32'd0);
        tick();
        check("mis_sh_clear", 32'(bus.st_misalign), 32'd0);
        do_store(32'h0000_3000, 32'h7777_7777, 3'b011);
        check("ill_pulse", 32'(bus.st_misalign), 32'd1);
        check("ill_count", 32'(bus.count), 32'd0);
        check("ill_req",   32'(bus.mem_req), 32'd0);
        tick();
        check("ill_clear", 32'(bus.st_misalign), 32'd0);

        // Three entries, then asynchronous reset mid-drain.
        do_store(32'h0000_5001, 32'h0000_005A, 3'b000);
        do_store(32'h0000_5004, 32'h0000_BEEF, 3'b001);
        do_store(32'h0000_5008, 32'h0102_0304, 3'b010);
        check("pre_rst_count", 32'(bus.count), 32'd3);
        check("sb1_be",        32'(bus.mem_be), 32'b0010);
        check("sb1_wdata",     bus.mem_wdata, 32'h5A5A_5A5A);
        do_ack();
        check("sh0_be",    32'(bus.mem_be), 32'b0011);
        check("sh0_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        do_store(32'h0000_500C, 32'h0A0B_0C0D, 3'b010);
        bus.mem_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_req",   32'(bus.mem_req), 32'd0);
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_addr",  bus.mem_addr, 32'h0);
        bus.mem_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        do_store(32'h0000_6000, 32'hCAFE_F00D, 3'b010);
        check("post_rst_count", 32'(bus.count), 32'd1);
        check("post_rst_addr",  bus.mem_addr, 32'h0000_6000);
        check("post_rst_data",  bus.mem_wdata, 32'hCAFE_F00D);
        do_ack();
        check("post_rst_empty", 32'(bus.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer directly downstream of the store-data formatter in the MEM stage.
- Accepts formatted stores (low-aligned data plus funct3 and byte address) and converts each to a word-aligned write with byte enables and lane-shifted data.
- Queues entries in a FIFO and drains them to data memory over a req/ack handshake, so the pipeline does not stall on slow memory writes.
- Flags loads whose word matches a pending store, so hazard logic can stall the load.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- st_valid  input  1  store request from MEM stage.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  32  byte address of the store.
- st_data  input  32  formatted store data, low-aligned (byte in [7:0], half in [15:0]).
- st_funct3  input  3  000 = SB, 001 = SH, 010 = SW.
- st_misalign  output  1  one-cycle pulse: the accepted store was misaligned or had an illegal funct3, and was dropped.
- mem_req  output  1  head entry valid, write requested.
- mem_ack  input  1  memory accepted the head write this cycle.
- mem_addr  output  32  word address of the head entry ([1:0] = 00).
- mem_wdata  output  32  lane-shifted write data of the head entry.
- mem_be  output  4  byte enables of the head entry.
- ld_valid  input  1  load in MEM stage.
- ld_addr  input  32  load byte address.
- ld_hazard  output  1  load word matches a buffered store.
- count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - count = 0, head and tail pointers = 0, all entry valid bits = 0, st_misalign = 0.
  - mem_req = 0; mem_addr, mem_wdata and mem_be = 0.
  - Buffered contents are discarded.
- Accept:
  - st_ready = (count != DEPTH), combinational from registered count.
  - A push occurs on a rising edge with st_valid && st_ready.
- Lane formatting at push (lo = st_addr[1:0]):
  - SB: be = 4'b0001 << lo; wdata = {4{st_data[7:0]}}.
  - SH: lo = 00 gives be = 0011; lo = 10 gives be = 1100; wdata = {2{st_data[15:0]}}. lo[0] = 1 is misaligned.
  - SW: be = 1111; wdata = st_data. lo != 00 is misaligned.
  - Any other funct3 is illegal.
  - Stored address = {st_addr[31:2], 2'b00}.
- Misaligned or illegal store:
  - Consumes the handshake, but no entry is written and count is unchanged.
  - st_misalign = 1 for exactly the following cycle. It is registered and cleared the next cycle unless another bad store arrives.
- Drain:
  - mem_req = (count != 0).
  - mem_addr, mem_wdata and mem_be are driven from the head entry registers. They stay stable while mem_req && !mem_ack.
  - A pop occurs on a rising edge with mem_req && mem_ack. mem_ack while mem_req = 0 is ignored.
- Latency: a store pushed into an empty buffer at edge t gives mem_req = 1 from just after t, one cycle later. There is no combinational path from st_* to mem_*.
- Ordering: strict FIFO; entries drain in acceptance order.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, st_ready = 0 even if mem_ack is high (no pass-through).
- Pointers wrap modulo DEPTH.
  - Full: count == DEPTH.
  - Empty: count == 0.
- Hazard:
  - ld_hazard = ld_valid && (some valid entry has addr[31:2] == ld_addr[31:2]). Combinational.
  - The entry being popped this cycle still counts as valid.
  - A store being pushed this cycle is not yet counted.

Test Plan:
- Reset, then idle: count = 0, mem_req = 0, st_ready = 1, ld_hazard = 0 with ld_valid = 1.
- SB with addr = 0x1003, data = 0x000000AB, mem_ack held 0 → next cycle mem_req = 1, mem_addr = 0x1000, mem_be = 1000, mem_wdata = 0xABABABAB; outputs hold until mem_ack = 1, then mem_req drops the following cycle.
- SH to 0x2002 (data 0x1234), then SW to 0x2004 (data 0xDEADBEEF), with no ack:
  - Head: be = 1100, wdata = 0x12341234.
  - After one ack, head: addr = 0x2004, be = 1111.
  - ld_addr = 0x2006 → ld_hazard = 1; ld_addr = 0x2008 → ld_hazard = 0.
- Fill DEPTH = 4 stores with mem_ack = 0 → st_ready = 0 and a fifth st_valid is not accepted. Then assert push and ack in the same cycle while not full → count unchanged; order is preserved across pointer wrap.
- SW to 0x3001, then SH to 0x3003, then funct3 = 011 → each produces a one-cycle st_misalign pulse; count stays 0 and mem_req stays 0.
- Assert rst asynchronously mid-drain with 3 entries → mem_req = 0 and count = 0 immediately, without waiting for a clock edge. Release rst and push a new SW → it is the first entry drained.
